// File: rtl/bus_source_encoder.sv
// Registered one-hot-to-binary bus source encoder with multi-driver conflict tracking.
// Define BUS_ENC_RR_EN to rotate the winner among conflicting requesters.
module bus_source_encoder #(
    parameter int N_SRC = 32,
    parameter int SEL_W = $clog2(N_SRC),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] src_req,
    input  logic             err_clr,
    output logic [SEL_W-1:0] sel_out,
    output logic             sel_valid,
    output logic             conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [N_SRC-1:0] conflict_vec
);

    function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = SEL_W'(i);
        end
    endfunction

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             conflict_q, conflict_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_SRC-1:0] vec_q, vec_d;
    logic             any_req;
    logic             multi_req;
    logic [SEL_W-1:0] winner;

    assign any_req   = |src_req;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_req = |(src_req & (src_req - N_SRC'(1)));

`ifdef BUS_ENC_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] above_mask;
    logic [N_SRC-1:0] above_req;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_above
        assign above_mask[gi] = (rr_ptr_q < SEL_W'(gi));
    end

    assign above_req = src_req & above_mask;
    // Nothing above the pointer means the search wraps back to index 0.
    assign winner    = (multi_req && |above_req) ? lowest_idx(above_req) : lowest_idx(src_req);
    assign rr_ptr_d  = multi_req ? winner : rr_ptr_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    assign winner = lowest_idx(src_req);
`endif

    always_comb begin
        sel_d      = any_req ? winner : sel_q;
        valid_d    = any_req;
        conflict_d = multi_req;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
            vec_d    = '0;
        end else if (multi_req) begin
            sticky_d = 1'b1;
            vec_d    = src_req;
            if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            vec_q      <= '0;
        end else begin
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
        end
    end

    assign sel_out         = sel_q;
    assign sel_valid       = valid_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;
    assign conflict_vec    = vec_q;

endmodule
